// File: rtl/sw_alloc_pkg.sv
// sw_alloc_pkg: shared sizes, port index type and output FSM encoding for the switch allocator.
package sw_alloc_pkg;
   localparam int NPORT = 5;
   localparam int PORTW = 3;
   typedef logic [PORTW-1:0] port_t;
   localparam port_t PTR_RST = port_t'(NPORT - 1);
   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;
   function automatic port_t rr_idx(input port_t p, input int k);
      return port_t'((int'(p) + k) % NPORT);
   endfunction
endpackage

// File: rtl/sw_alloc_rr_arb.sv
// rr_arb: combinational round-robin picker; scans from ptr+1 upward with wrap-around.
module rr_arb
   import sw_alloc_pkg::*;
(
   input  logic [NPORT-1:0] req,
   input  port_t            ptr,
   output logic [NPORT-1:0] gnt,
   output port_t            idx,
   output logic             vld
);
   always_comb begin
      gnt = '0;
      idx = '0;
      vld = 1'b0;
      for (int k = 1; k <= NPORT; k++) begin
         if (!vld && req[rr_idx(ptr, k)]) begin
            gnt[rr_idx(ptr, k)] = 1'b1;
            idx = rr_idx(ptr, k);
            vld = 1'b1;
         end
      end
   end
endmodule

// File: rtl/sw_alloc.sv
// sw_alloc: per-output packet-locking switch allocator; one round-robin picker and
// one IDLE/LOCKED FSM per output, grants decoded straight from the owner registers.
module sw_alloc
   import sw_alloc_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_,
   input  logic [NPORT-1:0]       req,
   input  logic [NPORT*PORTW-1:0] port,
   input  logic [NPORT-1:0]       ivalid,
   input  logic [NPORT-1:0]       tail,
   input  logic [NPORT-1:0]       abort,
   input  logic [NPORT-1:0]       ordy,
   output logic [NPORT*NPORT-1:0] grt,
   output logic [NPORT-1:0]       busy
);
   state_e           state_q [NPORT];
   state_e           state_d [NPORT];
   port_t            owner_q [NPORT];
   port_t            owner_d [NPORT];
   port_t            ptr_q   [NPORT];
   port_t            ptr_d   [NPORT];
   logic [NPORT-1:0] cand    [NPORT];
   logic [NPORT-1:0] win_gnt [NPORT];
   port_t            win_idx [NPORT];
   logic [NPORT-1:0] win_vld;
   logic [NPORT-1:0] held;
   logic [NPORT-1:0] claimed;

   always_comb begin
      grt  = '0;
      busy = '0;
      held = '0;
      for (int o = 0; o < NPORT; o++) begin
         busy[o] = state_q[o] == LOCKED;
         for (int i = 0; i < NPORT; i++) begin
            if (busy[o] && owner_q[o] == port_t'(i)) begin
               grt[i*NPORT+o] = 1'b1;
               held[i]        = 1'b1;
            end
         end
      end
   end

   // Out-of-range port values never match any output index, so they are never candidates.
   always_comb begin
      for (int o = 0; o < NPORT; o++) begin
         cand[o] = '0;
         for (int i = 0; i < NPORT; i++)
            cand[o][i] = req[i] && port[i*PORTW +: PORTW] == port_t'(o) && !held[i] && ordy[o];
      end
   end

   for (genvar o = 0; o < NPORT; o++) begin : g_arb
      rr_arb u_arb (
         .req (cand[o]),
         .ptr (ptr_q[o]),
         .gnt (win_gnt[o]),
         .idx (win_idx[o]),
         .vld (win_vld[o])
      );
   end

   // Lower output indices claim inputs first; a later output picking a claimed input stays IDLE.
   always_comb begin
      claimed = '0;
      for (int o = 0; o < NPORT; o++) begin
         state_d[o] = state_q[o];
         owner_d[o] = owner_q[o];
         ptr_d[o]   = ptr_q[o];
         if (state_q[o] == LOCKED) begin
            if ((ivalid[owner_q[o]] && tail[owner_q[o]]) || abort[owner_q[o]])
               state_d[o] = IDLE;
         end else if (win_vld[o] && (claimed & win_gnt[o]) == '0) begin
            state_d[o] = LOCKED;
            owner_d[o] = win_idx[o];
            ptr_d[o]   = win_idx[o];
            claimed    = claimed | win_gnt[o];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         for (int o = 0; o < NPORT; o++) begin
            state_q[o] <= IDLE;
            owner_q[o] <= '0;
            ptr_q[o]   <= PTR_RST;
         end
      end else begin
         for (int o = 0; o < NPORT; o++) begin
            state_q[o] <= state_d[o];
            owner_q[o] <= owner_d[o];
            ptr_q[o]   <= ptr_d[o];
         end
      end
   end
endmodule

// File: doc/sw_alloc.md
Name: sw_alloc

Overview:
- Switch allocator for the 5-port wormhole router crossbar.
- Takes per-input-channel requests (destination port, flit valid, tail, abort) and issues one-hot crossbar grants.
- Each output port is locked to one input for the whole packet; new owners are chosen round-robin.
- Sits between the input channels and the crossbar, replacing the crossbar's internal grant logic. Grants feed both the crossbar select and the input-channel grt_* pins.

Parameters:
- NPORT, 5, number of router ports (inputs = outputs).
- PORTW, 3, width of a port index field.

Ports:
- clk  input  1  router clock.
- rst_  input  1  reset, asynchronous, active-low.
- req  input  NPORT  req[i]: input i has a head flit or active packet wanting an output.
- port  input  NPORT*PORTW  port[i*PORTW +: PORTW]: requested output index for input i.
- ivalid  input  NPORT  ivalid[i]: flit from input i crosses the crossbar this cycle.
- tail  input  NPORT  tail[i]: the flit on input i is a tail flit (qualified by ivalid[i]).
- abort  input  NPORT  abort[i]: input i abandons its packet (forward-abort).
- ordy  input  NPORT  ordy[o]: output o has at least one free downstream VC.
- grt  output  NPORT*NPORT  grt[i*NPORT+o]: input i owns output o.
- busy  output  NPORT  busy[o]: output o is locked.

Behaviour:
- Reset values: all grt = 0; busy = 0; every output in IDLE; every rr pointer = NPORT-1, so input 0 has highest priority first.
- Per output o, a 2-state FSM with states IDLE and LOCKED, plus registers owner[o] (PORTW bits) and ptr[o] (PORTW bits).
- Candidate set for o in IDLE: input i is a candidate when req[i]=1, port[i]==o, the input holds no other grant, and ordy[o]=1.
  - A port value >= NPORT is ignored and never granted.
- Winner selection: the first candidate scanning i = ptr[o]+1, ptr[o]+2, ... modulo NPORT (wrap-around).
- IDLE -> LOCKED: taken when the candidate set is non-empty. On the next edge: owner[o] <= winner, ptr[o] <= winner, busy[o] <= 1.
- Grant output: grt[i*NPORT+o] = busy[o] && owner[o]==i. It is a combinational decode of registers, so there is 1 cycle of latency from req to grant.
- LOCKED -> IDLE: taken on an edge where, for the owner i:
  - ivalid[i] && tail[i], or
  - abort[i].
  - The grant is still asserted during the tail cycle and drops on the following cycle.
- Back-to-back packets: no same-cycle re-grant. After a release the output spends 1 IDLE cycle arbitrating, so there is a minimum 1-cycle bubble between packets on one output.
- In LOCKED: req, port and ordy are ignored, and ordy deassertion does not revoke a grant (the VC stall is handled by the input channel).
- Single-flit packet (head = tail): granted at cycle N+1, released at the edge ending N+1, busy = 0 at N+2.
- Mutual exclusion invariants:
  - Each input holds at most one grant.
  - Each output column of grt has at most one bit set.
- Simultaneous events:
  - Several outputs may lock in the same cycle to different inputs.
  - If two outputs pick the same input in one cycle, the lower output index wins and the other stays IDLE.
- A tail or abort from a non-owner input is ignored.
- rst_ low at any time, including mid-packet, clears state asynchronously and drops all grants immediately.

Decomposition:
- Shared package/header: NPORT, PORTW, the port index encodings, and the FSM state encoding (IDLE=0, LOCKED=1).
- Natural sub-module: rr_arb, an NPORT-wide round-robin picker.
  - Inputs: request vector and pointer. Output: one-hot grant plus index.
  - Purely combinational.
- sw_alloc instantiates one rr_arb per output and holds all FSM, owner and pointer registers.

Test Plan:
1. Reset: hold rst_=0, drive req=5'b11111 with all port=2 -> grt=0 and busy=0. Release reset -> input 0 is granted output 2 one cycle later (grt bit 0*5+2).
2. Round-robin: inputs 1 and 3 hold req for output 4, each sending 3-flit packets with tail on the 3rd flit, ordy[4]=1 -> sequence is input 1, bubble, input 3, bubble, input 1, with busy[4] dropping 1 cycle after each tail.
3. Wrap-around: ptr[0]=4 after input 4 finishes; inputs 0 and 4 both request output 0 -> input 0 wins.
4. Backpressure and abort:
   - ordy[1]=0 with input 2 requesting port 1 -> no grant for 10 cycles.
   - Raise ordy[1] -> grant next cycle.
   - Mid-packet abort[2] -> grant drops next cycle.
5. Parallel and conflict:
   - Inputs 0 through 4 request distinct outputs -> all 5 grants assert in the same cycle.
   - Invalid port=6 on input 3 -> never granted.
6. Reset mid-packet: assert rst_ while output 3 is locked to input 1 -> grt and busy clear asynchronously before the next edge. After release, arbitration restarts from input 0 priority.
